// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default clock rate.
package timer_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler counting 0..TICK_DIV-1 while enabled; wrap flags the terminal count.
// wrap is combinational from the count; clr takes precedence over en; count holds when en is low.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    assign wrap = en && !clr && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer FSM: counts load_val ticks of TICK_DIV clk cycles, with pause/resume/cancel.
// Outputs are registered (tick/done update on the edge that changes remaining); no backpressure.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int TICK_DIV = CLK_HZ,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             pause,
    input  logic             resume,
    input  logic             cancel,
    output logic             tick,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_o
);

    state_t state;
    logic   start_ok;
    logic   pre_en;
    logic   pre_clr;
    logic   wrap;

    // Start is only honoured from IDLE/DONE and loses to cancel.
    assign start_ok = start && !cancel && (state == ST_IDLE || state == ST_DONE);
    assign pre_en   = (state == ST_RUN) && !cancel;
    assign pre_clr  = cancel || start_ok;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .en   (pre_en),
        .clr  (pre_clr),
        .wrap (wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            tick      <= 1'b0;
            done      <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (cancel) begin
                state     <= ST_IDLE;
                remaining <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            if (load_val != '0) begin
                                state     <= ST_RUN;
                                remaining <= load_val;
                            end else begin
                                state     <= ST_DONE;
                                remaining <= '0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        // A pause landing on the wrap still takes that tick first.
                        if (wrap) begin
                            tick <= 1'b1;
                            if (remaining <= CNT_W'(1)) begin
                                remaining <= '0;
                                state     <= ST_DONE;
                                done      <= 1'b1;
                            end else begin
                                remaining <= remaining - CNT_W'(1);
                                if (pause) begin
                                    state <= ST_PAUSE;
                                end
                            end
                        end else if (pause) begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (resume) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy    = (state == ST_RUN) || (state == ST_PAUSE);
    assign state_o = state;

endmodule
